// File: rtl/mlp_pkg.sv
// Shared MLP definitions: default SRAM widths, arbiter owner encoding
// and the read-return tag carried alongside each SRAM command.
package mlp_pkg;

  localparam int MLP_ADDR_W = 16;
  localparam int MLP_DATA_W = 16;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_HOST = 2'd1;
  localparam logic [1:0] OWN_ENG  = 2'd2;

  typedef struct packed {
    logic valid;
    logic is_host;
  } rd_tag_t;

endpackage

// File: rtl/mlp_mem_arbiter_if.sv
// Requester-side and SRAM-side signals of the MLP memory arbiter.
// slave = arbiter view; master = requesters plus SRAM view.
interface mlp_mem_arbiter_if #(
  parameter int ADDR_W = mlp_pkg::MLP_ADDR_W,
  parameter int DATA_W = mlp_pkg::MLP_DATA_W
);
  logic              host_req;
  logic              host_lock;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic              eng_req;
  logic              eng_lock;
  logic              eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic              eng_gnt;
  logic              eng_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  host_req, host_lock, host_we, host_addr, host_wdata,
    input  eng_req, eng_lock, eng_we, eng_addr, eng_wdata,
    input  mem_rdata,
    output host_gnt, host_rvalid, eng_gnt, eng_rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output host_req, host_lock, host_we, host_addr, host_wdata,
    output eng_req, eng_lock, eng_we, eng_addr, eng_wdata,
    output mem_rdata,
    input  host_gnt, host_rvalid, eng_gnt, eng_rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mlp_rd_tag_pipe.sv
// Shift register of {valid, is_host} tags that tracks which requester
// owns the SRAM read data arriving RD_LAT+1 cycles after the grant.
module mlp_rd_tag_pipe
  import mlp_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t push,
  output rd_tag_t tail
);

  rd_tag_t stages [RD_LAT+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= RD_LAT; i++) stages[i] <= '0;
    end else begin
      stages[0] <= push;
      for (int i = 1; i <= RD_LAT; i++) stages[i] <= stages[i-1];
    end
  end

  assign tail = stages[RD_LAT];

endmodule

// File: rtl/mlp_mem_arbiter.sv
// Round-robin arbiter with lockable ownership and bounded lock time that
// shares the single-port MLP SRAM between the host loader and the engine.
module mlp_mem_arbiter
  import mlp_pkg::*;
#(
  parameter int ADDR_W   = MLP_ADDR_W,
  parameter int DATA_W   = MLP_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_LOCK = 256
) (
  input  logic              clk,
  input  logic              rst,
  mlp_mem_arbiter_if.slave  bus,
  output logic [1:0]        owner_state
);

  localparam int CNT_W = $clog2(MAX_LOCK) + 1;

  // Handshake: an access transfers in any cycle where req && gnt; a
  // requester that is not granted holds its fields and retries next cycle.
  logic [1:0]        owner_q, last_q;
  logic [CNT_W-1:0]  lock_cnt, cnt_now;
  logic              host_win, eng_win, acc, win_lock, win_we;
  logic              other_wait, timeout;
  logic [ADDR_W-1:0] win_addr, addr_q;
  logic [DATA_W-1:0] win_wdata, wdata_q, rdata_q;
  logic              en_q, we_q, host_rv_q, eng_rv_q;
  rd_tag_t           push_tag, tail_tag;

  always_comb begin
    host_win = 1'b0;
    eng_win  = 1'b0;
    case (owner_q)
      OWN_HOST: host_win = bus.host_req;
      OWN_ENG:  eng_win  = bus.eng_req;
      default: begin
        host_win = bus.host_req && (!bus.eng_req || last_q == OWN_ENG);
        eng_win  = bus.eng_req && (!bus.host_req || last_q == OWN_HOST);
      end
    endcase
    acc        = host_win || eng_win;
    win_lock   = host_win ? bus.host_lock  : bus.eng_lock;
    win_we     = host_win ? bus.host_we    : bus.eng_we;
    win_addr   = host_win ? bus.host_addr  : bus.eng_addr;
    win_wdata  = host_win ? bus.host_wdata : bus.eng_wdata;
    other_wait = host_win ? bus.eng_req    : bus.host_req;
    // cnt_now is the index of this grant among consecutive grants that made
    // the other side wait; the MAX_LOCK-th such grant is forced unlocked.
    cnt_now    = (owner_q == OWN_NONE) ? '0 : lock_cnt;
    timeout    = acc && win_lock && other_wait && (cnt_now == CNT_W'(MAX_LOCK - 1));
    push_tag.valid   = acc && !win_we;
    push_tag.is_host = host_win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      last_q   <= OWN_ENG;
      lock_cnt <= '0;
    end else if (acc) begin
      last_q <= host_win ? OWN_HOST : OWN_ENG;
      if (win_lock && !timeout) begin
        owner_q  <= host_win ? OWN_HOST : OWN_ENG;
        lock_cnt <= other_wait ? cnt_now + 1'b1 : cnt_now;
      end else begin
        owner_q  <= OWN_NONE;
        lock_cnt <= '0;
      end
    end else if (owner_q != OWN_NONE) begin
      owner_q  <= OWN_NONE;
      lock_cnt <= '0;
    end
  end

  mlp_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .push (push_tag),
    .tail (tail_tag)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      host_rv_q <= 1'b0;
      eng_rv_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      en_q <= acc;
      we_q <= acc && win_we;
      if (acc) begin
        addr_q  <= win_addr;
        wdata_q <= win_wdata;
      end
      host_rv_q <= tail_tag.valid && tail_tag.is_host;
      eng_rv_q  <= tail_tag.valid && !tail_tag.is_host;
      if (tail_tag.valid) rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.host_gnt    = host_win;
  assign bus.eng_gnt     = eng_win;
  assign bus.mem_en      = en_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.host_rvalid = host_rv_q;
  assign bus.eng_rvalid  = eng_rv_q;
  assign bus.rdata       = rdata_q;
  assign owner_state     = owner_q;

endmodule

// File: tb/tb_mlp_mem_arbiter.sv
// Directed bench for mlp_mem_arbiter: main instance (MAX_LOCK=256) with an
// SRAM model, plus a MAX_LOCK=4 instance for the lock timeout.
module tb_mlp_mem_arbiter;
  import mlp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sram_load = 1'b1;
  logic [1:0] owner_a, owner_b;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  mlp_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b ();
  mlp_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) t ();

  mlp_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .MAX_LOCK(256)) dut (
    .clk(clk), .rst(rst), .bus(b), .owner_state(owner_a));

  mlp_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .MAX_LOCK(4)) dut_to (
    .clk(clk), .rst(rst), .bus(t), .owner_state(owner_b));

  // SRAM model, one cycle read latency; preload A0xx pattern plus 0xBEEF at 0x10
  logic [15:0] sram [0:255];
  logic [15:0] rd_q;
  always @(posedge clk) begin
    if (sram_load) begin
      for (int i = 0; i < 256; i++) sram[i] <= 16'hA000 | 16'(i);
      sram[8'h10] <= 16'hBEEF;
    end else if (b.mem_en) begin
      if (b.mem_we) sram[b.mem_addr[7:0]] <= b.mem_wdata;
      else rd_q <= sram[b.mem_addr[7:0]];
    end
  end
  assign b.mem_rdata = rd_q;
  assign t.mem_rdata = 16'h0000;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b.host_req = 0; b.host_lock = 0; b.host_we = 0; b.host_addr = 0; b.host_wdata = 0;
    b.eng_req = 0; b.eng_lock = 0; b.eng_we = 0; b.eng_addr = 0; b.eng_wdata = 0;
    t.host_req = 0; t.host_lock = 0; t.host_we = 0; t.host_addr = 0; t.host_wdata = 0;
    t.eng_req = 0; t.eng_lock = 0; t.eng_we = 0; t.eng_addr = 0; t.eng_wdata = 0;
  endtask

  task automatic idle_cycles(input int n);
    idle_all();
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    idle_all();
    cyc(); cyc();
    @(negedge clk);
    checks++; if (b.host_gnt !== 1'b0 || b.eng_gnt !== 1'b0) $display("FAIL reset_gnt got %b%b want 00", b.host_gnt, b.eng_gnt); else passes++;
    checks++; if (b.mem_en !== 1'b0 || b.mem_we !== 1'b0) $display("FAIL reset_mem got en=%b we=%b want 0 0", b.mem_en, b.mem_we); else passes++;
    checks++; if (b.mem_addr !== 16'h0 || b.mem_wdata !== 16'h0) $display("FAIL reset_addr got %h/%h want 0000/0000", b.mem_addr, b.mem_wdata); else passes++;
    checks++; if (b.host_rvalid !== 1'b0 || b.eng_rvalid !== 1'b0) $display("FAIL reset_rvalid got %b%b want 00", b.host_rvalid, b.eng_rvalid); else passes++;
    checks++; if (b.rdata !== 16'h0) $display("FAIL reset_rdata got %h want 0000", b.rdata); else passes++;
    checks++; if (owner_a !== OWN_NONE) $display("FAIL reset_owner got %0d want 0", owner_a); else passes++;
    cyc();
    rst = 1'b0;
    sram_load = 1'b0;
    cyc();
  endtask

  task automatic test_host_read();
    cyc(); b.host_req = 1; b.host_we = 0; b.host_addr = 16'h0010;
    @(negedge clk);
    checks++; if (b.host_gnt !== 1'b1 || b.eng_gnt !== 1'b0) $display("FAIL hread_gnt got %b%b want 10", b.host_gnt, b.eng_gnt); else passes++;
    cyc(); b.host_req = 0;
    @(negedge clk);
    checks++; if (b.mem_en !== 1'b1 || b.mem_we !== 1'b0) $display("FAIL hread_cmd got en=%b we=%b want 1 0", b.mem_en, b.mem_we); else passes++;
    checks++; if (b.mem_addr !== 16'h0010) $display("FAIL hread_addr got %h want 0010", b.mem_addr); else passes++;
    cyc(); @(negedge clk);
    checks++; if (b.host_rvalid !== 1'b0) $display("FAIL hread_early got %b want 0", b.host_rvalid); else passes++;
    cyc(); @(negedge clk);
    checks++; if (b.host_rvalid !== 1'b1 || b.eng_rvalid !== 1'b0) $display("FAIL hread_rvalid got %b%b want 10", b.host_rvalid, b.eng_rvalid); else passes++;
    checks++; if (b.rdata !== 16'hBEEF) $display("FAIL hread_data got %h want beef", b.rdata); else passes++;
    cyc(); @(negedge clk);
    checks++; if (b.host_rvalid !== 1'b0 || b.rdata !== 16'hBEEF) $display("FAIL hread_hold got rv=%b data=%h want 0 beef", b.host_rvalid, b.rdata); else passes++;
    idle_cycles(2);
  endtask

  // last grant was host, so the engine wins the first tie (even j = engine)
  task automatic test_round_robin();
    logic [15:0] exp_addr;
    for (int j = 0; j < 10; j++) begin
      cyc();
      b.host_req = (j < 6); b.host_we = 0; b.host_addr = 16'h0020;
      b.eng_req  = (j < 6); b.eng_we  = 0; b.eng_addr  = 16'h0021;
      @(negedge clk);
      if (j < 6) begin
        checks++;
        if (b.host_gnt !== (j % 2 == 1) || b.eng_gnt !== (j % 2 == 0))
          $display("FAIL rr_gnt cyc %0d got %b%b want %b%b", j, b.host_gnt, b.eng_gnt, j % 2 == 1, j % 2 == 0);
        else passes++;
      end
      if (j >= 1 && j < 7) begin
        exp_addr = ((j - 1) % 2 == 0) ? 16'h0021 : 16'h0020;
        checks++; if (b.mem_addr !== exp_addr || b.mem_en !== 1'b1) $display("FAIL rr_addr cyc %0d got %h want %h", j, b.mem_addr, exp_addr); else passes++;
      end
      if (j >= 3 && j < 9) begin
        checks++;
        if (b.host_rvalid !== ((j - 3) % 2 == 1) || b.eng_rvalid !== ((j - 3) % 2 == 0))
          $display("FAIL rr_route cyc %0d got %b%b", j, b.host_rvalid, b.eng_rvalid);
        else passes++;
        exp_addr = ((j - 3) % 2 == 0) ? 16'hA021 : 16'hA020;
        checks++; if (b.rdata !== exp_addr) $display("FAIL rr_data cyc %0d got %h want %h", j, b.rdata, exp_addr); else passes++;
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_lock();
    logic [1:0] exp_g;
    for (int c = 0; c < 12; c++) begin
      cyc();
      b.host_req = 1; b.host_we = 0; b.host_addr = 16'h0030;
      b.eng_req = 1; b.eng_we = 1; b.eng_addr = 16'h0040 + 16'(c); b.eng_wdata = 16'(c);
      b.eng_lock = (c < 10);
      @(negedge clk);
      exp_g = (c < 11) ? 2'b01 : 2'b10;
      checks++; if ({b.host_gnt, b.eng_gnt} !== exp_g) $display("FAIL lock_gnt cyc %0d got %b%b want %b", c, b.host_gnt, b.eng_gnt, exp_g); else passes++;
      if (c == 5) begin
        checks++; if (owner_a !== OWN_ENG) $display("FAIL lock_owner got %0d want 2", owner_a); else passes++;
      end
    end
    idle_cycles(5);
  endtask

  // MAX_LOCK=4 instance: host first so the locked engine wins the tie
  task automatic test_timeout();
    logic [1:0] exp_to [7];
    exp_to[0] = 2'b01; exp_to[1] = 2'b01; exp_to[2] = 2'b01; exp_to[3] = 2'b01;
    exp_to[4] = 2'b10; exp_to[5] = 2'b01; exp_to[6] = 2'b01;
    cyc(); t.host_req = 1; t.host_we = 1;
    @(negedge clk);
    checks++; if ({t.host_gnt, t.eng_gnt} !== 2'b10) $display("FAIL to_first got %b%b want 10", t.host_gnt, t.eng_gnt); else passes++;
    for (int c = 0; c < 7; c++) begin
      cyc();
      t.host_req = 1; t.host_we = 1; t.host_lock = 0;
      t.eng_req = 1; t.eng_we = 1; t.eng_lock = 1; t.eng_addr = 16'(c);
      @(negedge clk);
      checks++; if ({t.host_gnt, t.eng_gnt} !== exp_to[c]) $display("FAIL to_gnt cyc %0d got %b%b want %b", c, t.host_gnt, t.eng_gnt, exp_to[c]); else passes++;
    end
    idle_cycles(2);
  endtask

  task automatic test_write_then_read();
    cyc(); b.eng_req = 1; b.eng_we = 1; b.eng_addr = 16'h0005; b.eng_wdata = 16'h0123;
    @(negedge clk);
    checks++; if (b.eng_gnt !== 1'b1) $display("FAIL wr_gnt got %b want 1", b.eng_gnt); else passes++;
    cyc(); b.eng_req = 0; b.host_req = 1; b.host_we = 0; b.host_addr = 16'h0005;
    @(negedge clk);
    checks++; if (b.host_gnt !== 1'b1) $display("FAIL wr_rd_gnt got %b want 1", b.host_gnt); else passes++;
    checks++; if (b.mem_en !== 1'b1 || b.mem_we !== 1'b1) $display("FAIL wr_cmd got en=%b we=%b want 1 1", b.mem_en, b.mem_we); else passes++;
    checks++; if (b.mem_addr !== 16'h0005 || b.mem_wdata !== 16'h0123) $display("FAIL wr_fields got %h/%h want 0005/0123", b.mem_addr, b.mem_wdata); else passes++;
    cyc(); b.host_req = 0;
    @(negedge clk);
    checks++; if (b.mem_en !== 1'b1 || b.mem_we !== 1'b0) $display("FAIL rd_cmd got en=%b we=%b want 1 0", b.mem_en, b.mem_we); else passes++;
    cyc(); @(negedge clk);
    checks++; if (b.host_rvalid !== 1'b0 || b.eng_rvalid !== 1'b0) $display("FAIL wr_noresp got %b%b want 00", b.host_rvalid, b.eng_rvalid); else passes++;
    cyc(); @(negedge clk);
    checks++; if (b.host_rvalid !== 1'b1 || b.eng_rvalid !== 1'b0) $display("FAIL wr_rd_rvalid got %b%b want 10", b.host_rvalid, b.eng_rvalid); else passes++;
    checks++; if (b.rdata !== 16'h0123) $display("FAIL wr_rd_data got %h want 0123", b.rdata); else passes++;
    idle_cycles(3);
  endtask

  task automatic test_reset_midflight();
    int stray;
    cyc(); b.host_req = 1; b.host_we = 0; b.host_addr = 16'h0010;
    cyc(); b.host_req = 0; b.eng_req = 1; b.eng_we = 0; b.eng_addr = 16'h0021;
    cyc(); b.eng_req = 0;
    #2 rst = 1'b1;
    #1;
    checks++; if (b.mem_en !== 1'b0 || b.mem_addr !== 16'h0) $display("FAIL arst_mem got en=%b addr=%h want 0 0000", b.mem_en, b.mem_addr); else passes++;
    checks++; if (b.rdata !== 16'h0) $display("FAIL arst_rdata got %h want 0000", b.rdata); else passes++;
    checks++; if (b.host_rvalid !== 1'b0 || b.eng_rvalid !== 1'b0) $display("FAIL arst_rvalid got %b%b want 00", b.host_rvalid, b.eng_rvalid); else passes++;
    cyc();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b.host_rvalid === 1'b1 || b.eng_rvalid === 1'b1) stray++;
      cyc();
    end
    checks++; if (stray !== 0) $display("FAIL arst_stray got %0d rvalids want 0", stray); else passes++;
    b.host_req = 1; b.host_we = 0; b.host_addr = 16'h0010;
    @(negedge clk);
    checks++; if (b.host_gnt !== 1'b1) $display("FAIL arst_regrant got %b want 1", b.host_gnt); else passes++;
    cyc(); b.host_req = 0;
    cyc(); cyc(); @(negedge clk);
    checks++; if (b.host_rvalid !== 1'b1 || b.rdata !== 16'hBEEF) $display("FAIL arst_read got rv=%b data=%h want 1 beef", b.host_rvalid, b.rdata); else passes++;
    idle_cycles(2);
  endtask

  initial begin
    idle_all();
    test_reset();
    test_host_read();
    test_round_robin();
    test_lock();
    test_timeout();
    test_write_then_read();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mlp_mem_arbiter.md
Name: mlp_mem_arbiter

Overview:
Shares the single-port MLP neuron/weight SRAM between two requesters: the host loader (weights, inputs, result readback) and the inference engine (the MLP control unit's address stream).
- Per-cycle round-robin arbitration, with an optional lock so an engine layer pass runs uninterrupted.
- A bounded lock timeout prevents host starvation.
- Registers the SRAM command and routes read data back to the requester that issued each read.

Parameters:
ADDR_W, 16, SRAM address width (matches the weight address width).
DATA_W, 16, SRAM data width.
RD_LAT, 1, SRAM read latency in cycles from registered mem_en; legal 1-4.
MAX_LOCK, 256, maximum consecutive locked grants to one requester while the other waits.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
host_req  in  1  host access request.
host_lock  in  1  host requests to keep ownership after this access.
host_we  in  1  1 = write, 0 = read.
host_addr  in  ADDR_W  host address.
host_wdata  in  DATA_W  host write data.
host_gnt  out  1  host access accepted this cycle (combinational).
host_rvalid  out  1  rdata holds a host read result.
eng_req, eng_lock, eng_we, eng_addr, eng_wdata  in  1/1/1/ADDR_W/DATA_W  engine equivalents.
eng_gnt  out  1  engine access accepted this cycle.
eng_rvalid  out  1  rdata holds an engine read result.
rdata  out  DATA_W  read data; shared by both requesters, qualified by the rvalids.
mem_en, mem_we  out  1  registered SRAM enable and write strobe.
mem_addr, mem_wdata  out  ADDR_W/DATA_W  registered SRAM address and write data.
mem_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after a read command.

Behaviour:
- Reset values: host_gnt=0, eng_gnt=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, host_rvalid=0, eng_rvalid=0, rdata=0.
- Reset internal state: owner=NONE, last=ENG (host wins the first tie), lock_cnt=0, tag pipeline cleared.
- Reset mid-operation drops in-flight reads: no rvalid is produced for them.
- An access is accepted in the cycle where req && gnt. At most one gnt is high per cycle.
- Grant logic is combinational from current reqs plus registered owner/last/lock_cnt.
- Owner FSM states: NONE, HOST, ENG.
  - NONE: grant the sole requester. If both request, grant the requester != last.
  - HOST or ENG (locked): grant the owner while its req=1. The other requester is blocked.
  - Ownership is taken when an accepted access has lock=1. Next state = that requester.
  - Ownership is released to NONE when an accepted access has lock=0, or the owner's req drops.
  - Released ownership is re-arbitrated in the next cycle; there is no same-cycle handover.
- Timeout:
  - lock_cnt increments for each owner grant while the other req=1. It resets to 0 on any ownership change.
  - When lock_cnt==MAX_LOCK-1, the current grant is forced unlocked. Owner becomes NONE and last = owner, so the waiter wins the next cycle.
- last updates on every accepted access.
- SRAM command: on acceptance, mem_en<=1 and mem_we/addr/wdata <= the winner's fields on the next edge. Otherwise mem_en<=0 and mem_we<=0; addr and wdata hold.
- Latency: grant at cycle N → mem_en at N+1 → mem_rdata at N+1+RD_LAT → rdata/rvalid registered at N+2+RD_LAT.
  - With RD_LAT=1, read-to-rvalid latency is 3 cycles.
- Tag pipeline:
  - Depth RD_LAT+1. Each entry holds {valid, is_host}, pushed every cycle.
  - A read sets valid=1; a write or no access sets valid=0.
  - At the tail, the tag selects host_rvalid or eng_rvalid for one cycle, and rdata <= mem_rdata.
  - rdata holds when neither rvalid fires.
- Back-to-back reads give one result per cycle, in order. Interleaved owners are routed correctly.
- Writes produce no response.
- A request whose gnt is low is not accepted. The requester holds its fields and retries the same command in the next cycle.

Decomposition:
- Shared package mlp_pkg holds:
  - owner encoding localparams: OWN_NONE=0, OWN_HOST=1, OWN_ENG=2;
  - default ADDR_W/DATA_W, shared with the MLP control unit.
- One natural sub-module: mlp_rd_tag_pipe (parameterised RD_LAT shift register of {valid, is_host}).

Test Plan:
- Reset, then host read 0x0010 with SRAM model data 0xBEEF → host_gnt same cycle; mem_en/addr=0x0010 next cycle; host_rvalid=1 with rdata=0xBEEF 3 cycles after grant; eng_rvalid stays 0.
- Both req continuously with lock=0 → gnts alternate host, eng, host, eng…; mem_addr alternates accordingly; each rvalid is routed to the correct side.
- eng_lock=1 for 10 accesses while host_req=1 → eng_gnt for all 10, host_gnt=0 throughout; host granted in the cycle after the first eng access with lock=0.
- MAX_LOCK=4, eng_req=eng_lock=1 held, host_req=1 → exactly 4 eng grants, then 1 host grant, then the engine reacquires.
- Engine write 0x0123 to addr 0x0005, then host read 0x0005 → mem_we=1 then mem_we=0 in consecutive cycles; host_rvalid returns 0x0123; no rvalid is produced for the write.
- Assert rst with 2 reads in flight → all outputs 0 asynchronously; neither rvalid fires after release; the first request after release is granted.
